// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and opcode helpers shared by the ALU arbiter.
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1101;
  localparam logic [3:0] OP_NOR = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_NOT, OP_NOR};
  endfunction

  // Only add and sub produce meaningful carry/overflow.
  function automatic logic has_flags(input logic [3:0] op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals of the shared-ALU arbiter.
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [3:0]       req0_op;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [3:0]       alu_op;
  logic             alu_carry, alu_over;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry, rsp_over, rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_carry, alu_over,
    output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_over, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_carry, alu_over,
    input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_over, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; ptr_i = 1 favours requester 1 when both are valid.
module rr_arb2 (
    input  logic v0_i,
    input  logic v1_i,
    input  logic ptr_i,
    output logic g0_o,
    output logic g1_o
);
    assign g0_o = v0_i && (!v1_i || !ptr_i);
    assign g1_o = v1_i && (!v0_i || ptr_i);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with round-robin
// arbitration, registered operands/results, opcode checking and flag masking.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    state_t           state_q, state_d;
    logic             ptr_q, ptr_d, id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [3:0]       op_q, op_d;
    logic             carry_q, carry_d, over_q, over_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             g0, g1, idle, exec;

    rr_arb2 u_arb (
        .v0_i (bus.req0_valid),
        .v1_i (bus.req1_valid),
        .ptr_i(ptr_q),
        .g0_o (g0),
        .g1_o (g1)
    );

    assign idle = state_q == S_IDLE;
    assign exec = state_q == S_EXEC;

    // rst_n gating keeps ready low while reset is held, even if a requester is valid.
    assign bus.req0_ready = idle && g0 && rst_n;
    assign bus.req1_ready = idle && g1 && rst_n;
    assign bus.alu_a      = exec ? a_q  : '0;
    assign bus.alu_b      = exec ? b_q  : '0;
    assign bus.alu_op     = exec ? op_q : '0;
    assign bus.rsp_valid  = state_q == S_RESP;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_over   = over_q;
    assign bus.rsp_err    = err_q;
    assign busy           = !idle;
    assign op_count       = cnt_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        carry_d = carry_q;
        over_d  = over_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (g0 || g1) begin
                state_d = S_EXEC;
                ptr_d   = g0;
                id_d    = g1;
                a_d     = g1 ? bus.req1_a  : bus.req0_a;
                b_d     = g1 ? bus.req1_b  : bus.req0_b;
                op_d    = g1 ? bus.req1_op : bus.req0_op;
            end
            S_EXEC: begin
                state_d = S_RESP;
                err_d   = !is_legal_op(op_q);
                data_d  = is_legal_op(op_q) ? bus.alu_out : '0;
                carry_d = has_flags(op_q) && bus.alu_carry;
                over_d  = has_flags(op_q) && bus.alu_over;
            end
            S_RESP: if (bus.rsp_ready) begin
                state_d = S_IDLE;
                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            over_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            over_q  <= over_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, masking, backpressure, reset and
// counter wrap; the DUT runs with a 2-bit counter so wrap is reachable.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [1:0]  op_count;
    logic        force_c = 1'b0;
    logic [31:0] r;
    logic        c, v;
    int          checks = 0, failures = 0, exp_cnt = 0, cyc_n = 0, last_hs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32), .CNT_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .op_count(op_count)
    );

    // Behavioural ALU; unknown opcodes return junk with both flags set so masking is visible.
    always_comb begin
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (bus.alu_op)
            OP_ADD: begin
                {c, r} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                v = (bus.alu_a[31] == bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
            end
            OP_SUB: begin
                {c, r} = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
                v = (bus.alu_a[31] != bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
            end
            OP_AND:  r = bus.alu_a & bus.alu_b;
            OP_OR:   r = bus.alu_a | bus.alu_b;
            OP_SLT:  r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            OP_NOT:  r = ~bus.alu_a;
            OP_NOR:  r = ~(bus.alu_a | bus.alu_b);
            default: begin
                r = bus.alu_a ^ bus.alu_b;
                c = 1'b1;
                v = 1'b1;
            end
        endcase
        bus.alu_out   = r;
        bus.alu_carry = c || force_c;
        bus.alu_over  = v;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input bit val, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
        if (id) begin
            bus.req1_valid = val; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = val; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] ed, input bit ec,
                          input bit eo, input bit ee);
        drive(id, 1'b1, a, b, op);
        #1;
        chk("grant", 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
        cyc();
        drive(id, 1'b0, '0, '0, '0);
        chk("exec_op", 32'(bus.alu_op), 32'(op));
        chk("exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
        cyc();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_data", bus.rsp_data, ed);
        chk("rsp_carry", 32'(bus.rsp_carry), 32'(ec));
        chk("rsp_over", 32'(bus.rsp_over), 32'(eo));
        chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
        chk("rsp_id", 32'(bus.rsp_id), 32'(id));
        cyc();
        exp_cnt++;
        chk("op_count", 32'(op_count), 32'(exp_cnt % 4));
        chk("back_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0);
        bus.rsp_ready = 1'b1;
        repeat (2) cyc();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        rst_n = 1'b1;
        cyc();

        run_op(1'b0, 32'h7FFFFFFF, 32'd1, OP_ADD, 32'h80000000, 1'b0, 1'b1, 1'b0);

        // Backpressure on a sub; both requesters pending throughout.
        drive(1'b0, 1'b1, 32'd5, 32'd7, OP_SUB);
        #1;
        chk("bp_grant", 32'(bus.req0_ready), 32'd1);
        cyc();
        bus.rsp_ready = 1'b0;
        bus.req1_valid = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_data", bus.rsp_data, 32'hFFFFFFFE);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            chk("bp_count", 32'(op_count), 32'(exp_cnt % 4));
            cyc();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_accept_valid", 32'(bus.rsp_valid), 32'd1);
        cyc();
        exp_cnt++;
        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0);
        chk("bp_count_inc", 32'(op_count), 32'(exp_cnt % 4));
        chk("bp_idle", 32'(busy), 32'd0);

        run_op(1'b1, 32'h12345678, 32'd1, 4'b0110, 32'd0, 1'b0, 1'b0, 1'b1);
        force_c = 1'b1;
        run_op(1'b0, 32'hF0F0F0F0, 32'hFF00FF00, OP_AND, 32'hF000F000, 1'b0, 1'b0, 1'b0);
        force_c = 1'b0;
        run_op(1'b1, 32'hFFFFFFFF, 32'd1, OP_SLT, 32'd1, 1'b0, 1'b0, 1'b0);

        // Reset in EXEC aborts the operation.
        drive(1'b1, 1'b1, 32'd3, 32'd4, OP_ADD);
        cyc();
        drive(1'b1, 1'b0, '0, '0, '0);
        chk("mid_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_alu_a", bus.alu_a, 32'd0);
        chk("mr_alu_op", 32'(bus.alu_op), 32'd0);
        chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mr_count", 32'(op_count), 32'd0);
        chk("mr_ready0", 32'(bus.req0_ready), 32'd0);
        chk("mr_ready1", 32'(bus.req1_ready), 32'd0);
        exp_cnt = 0;
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // Fairness with both requesters always valid; also walks the counter through wrap.
        drive(1'b0, 1'b1, 32'd10, 32'd20, OP_ADD);
        drive(1'b1, 1'b1, 32'd100, 32'd1, OP_SUB);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fair_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
            chk("fair_ready1", 32'(bus.req1_ready), 32'(i % 2 == 1));
            if (i > 0) chk("fair_spacing", 32'(cyc_n - last_hs), 32'd3);
            last_hs = cyc_n;
            cyc();
            cyc();
            chk("fair_id", 32'(bus.rsp_id), 32'(i % 2));
            chk("fair_data", bus.rsp_data, (i % 2 == 1) ? 32'd99 : 32'd30);
            cyc();
            exp_cnt++;
            chk("fair_count", 32'(op_count), 32'(exp_cnt % 4));
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0);
        run_op(1'b0, 32'd2, 32'd2, OP_ADD, 32'd4, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit combinational ALU (add/sub/and/or/slt/not/nor, 4-bit opcode) between two requesters.
- Round-robin arbitration, valid/ready request and response handshakes, and registered operands and results so ALU timing is isolated.
- Checks opcodes and masks flags that are not meaningful for the operation.
- Sits between the instruction-issue logic and the ALU instance, and drives the ALU's A, B and opCode inputs directly.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  4  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_op  out  4  opcode to the ALU.
- alu_out  in  WIDTH  ALU result.
- alu_carry  in  1  ALU carry.
- alu_over  in  1  ALU overflow.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  index of the requester that issued the response.
- rsp_data  out  WIDTH  registered result.
- rsp_carry, rsp_over  out  1  registered flags.
- rsp_err  out  1  illegal opcode.
- busy  out  1  state is not IDLE.
- op_count  out  CNT_W  number of completed responses.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - The round-robin pointer favours requester 0.
  - op_count is 0.
  - Reset asserted mid-operation aborts the transaction silently; no response is produced.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester the pointer favours.
  - reqN_ready is combinational: high only in IDLE and only for the granted requester.
  - On handshake (valid & ready): capture a, b, op and id into operand registers, flip the pointer to favour the other requester, go to EXEC.
  - No valid requester: stay in IDLE, both ready signals low.
- EXEC (exactly 1 cycle):
  - alu_a, alu_b and alu_op drive from the operand registers.
  - At the clock edge, capture alu_out, alu_carry and alu_over into the response registers, then go to RESP.
  - Outside EXEC, alu_a, alu_b and alu_op are driven to 0.
- Opcode legality and flag masking:
  - Legal opcodes are 0001 add, 0011 sub, 0100 and, 1000 or, 1010 slt, 1101 not, 1111 nor.
  - Any other opcode: rsp_err = 1, rsp_data = 0, rsp_carry = rsp_over = 0.
  - For legal non-add/sub opcodes, rsp_carry and rsp_over are forced to 0.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_id, rsp_carry, rsp_over and rsp_err are held stable while rsp_ready is low.
  - On rsp_valid & rsp_ready: op_count increments (wraps modulo 2^CNT_W), then go to IDLE.
  - No new request is accepted in RESP.
- Latency and throughput:
  - Request handshake to rsp_valid is 2 cycles.
  - Minimum spacing is 3 cycles per operation.
- busy = (state != IDLE).
- A requester that deasserts valid while not granted loses nothing. Requests are sampled only at handshake.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD = 4'b0001, OP_SUB = 4'b0011, OP_AND = 4'b0100, OP_OR = 4'b1000, OP_SLT = 4'b1010, OP_NOT = 4'b1101, OP_NOR = 4'b1111;
  - state encoding S_IDLE, S_EXEC, S_RESP;
  - the function is_legal_op.
- One sub-module, rr_arb2: 2-way round-robin grant logic (inputs: the two valids, the pointer; outputs: the two grants). The FSM, registers and flag masking stay in alu_arbiter.

Test Plan:
- Single add: req0 with a = 0x7FFFFFFF, b = 1, op = 0001, rsp_ready = 1. Expect rsp_valid 2 cycles after the handshake, rsp_data = 0x80000000, rsp_over = 1, rsp_carry = 0, rsp_id = 0, op_count = 1.
- Fairness: both requesters hold valid continuously for 4 operations. Expect grants in the order 0, 1, 0, 1 and every handshake spaced exactly 3 cycles apart.
- Backpressure: rsp_ready held low for 5 cycles during a sub (a = 5, b = 7). rsp_valid and rsp_data = 0xFFFFFFFE must stay stable, both reqN_ready stay low, and op_count increments only on the accepting cycle.
- Illegal and masked ops:
  - op = 0110 -> rsp_err = 1, rsp_data = 0, rsp_carry = rsp_over = 0.
  - op = 0100 (and) with the ALU model driving carry = 1 -> rsp_carry = 0.
- Reset mid-operation: assert rst_n = 0 in EXEC. All outputs must go to 0 immediately, with no response after release; the next simultaneous request is granted to requester 0.
- Counter wrap: with CNT_W = 2, complete 5 operations -> op_count sequence 1, 2, 3, 0, 1.
